// File: rtl/loop_seq_pkg.sv
// Shared definitions for the loop counter sequencer: FSM state encoding and default counter width.
package loop_seq_pkg;

  localparam int LOOP_SEQ_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } loop_state_e;

endpackage

// File: rtl/loop_counter_seq.sv
// Do-while loop counter: presents one counter value per beat over a valid/ready
// handshake, from init+1 up to a captured limit, with abort and a completion pulse.
//
//   state | meaning
//   IDLE  | waiting for start; init/limit captured on acceptance
//   LOAD  | first increment of the counter (body always runs once)
//   RUN   | cnt offered downstream; advance or finish on each accepted beat
//   DONE  | one-cycle done pulse, then back to IDLE
module loop_counter_seq
  import loop_seq_pkg::*;
#(
  parameter int WIDTH = LOOP_SEQ_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] limit,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] final_cnt
);

  loop_state_e      r_state;
  loop_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_final;
  logic             w_start_acc;
  logic             w_beat_acc;
  logic             w_more;

  always_comb begin
    w_start_acc = 1'b0;
    w_beat_acc  = 1'b0;
    w_more      = 1'b0;
    w_state_nxt = r_state;
    w_start_acc = (r_state == IDLE) && start && !abort;
    // abort takes priority over a beat that would otherwise be accepted
    w_beat_acc  = (r_state == RUN) && cnt_ready && !abort;
    w_more      = (r_counter < r_limit);
    case (r_state)
      IDLE: if (w_start_acc) w_state_nxt = LOAD;
      LOAD: w_state_nxt = abort ? IDLE : RUN;
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_beat_acc && !w_more) begin
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_counter <= '0;
      r_limit   <= '0;
      r_final   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_start_acc) begin
            r_counter <= init;
            r_limit   <= limit;
          end
        end
        LOAD: begin
          if (!abort) r_counter <= WIDTH'(r_counter + 1'b1);
        end
        RUN: begin
          if (w_beat_acc) begin
            if (w_more) r_counter <= WIDTH'(r_counter + 1'b1);
            else        r_final   <= r_counter;
          end
        end
        default: ;
      endcase
    end
  end

  assign cnt       = r_counter;
  assign cnt_valid = (r_state == RUN);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE) && !abort;
  assign final_cnt = r_final;

endmodule

// File: tb/tb_loop_counter_seq.sv
// Directed bench for loop_counter_seq with a beat scoreboard fed by a reference loop model.
module tb_loop_counter_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] init;
  logic [W-1:0] limit;
  logic         abort;
  logic [W-1:0] cnt;
  logic         cnt_valid;
  logic         cnt_ready;
  logic         busy;
  logic         done;
  logic [W-1:0] final_cnt;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           acc_cyc = -10;
  int           n_done = 0;
  logic [W-1:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_cnt = '0;

  loop_counter_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .init      (init),
    .limit     (limit),
    .abort     (abort),
    .cnt       (cnt),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .busy      (busy),
    .done      (done),
    .final_cnt (final_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Beat monitor: compares each accepted beat against the scoreboard and
  // checks that a stalled beat holds its value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid_held", cnt_valid, 1);
        chk("stall_cnt_held", cnt, prev_cnt);
      end
      if (cnt_valid && cnt_ready && !abort) begin
        acc_cyc = cyc;
        if (exp_q.size() == 0) chk("beat_unexpected_qsize", exp_q.size(), 1);
        else                   chk("beat", cnt, exp_q.pop_front());
      end
      if (done) begin
        n_done++;
        chk("done_without_valid", cnt_valid, 0);
      end
      prev_stall = cnt_valid && !cnt_ready && !abort;
      prev_cnt   = cnt;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference loop: first beat init+1, advance while below limit, wrap mod 2^W.
  task automatic push_model(input logic [W-1:0] i, input logic [W-1:0] l, input int maxn);
    logic [W-1:0] v;
    v = i + 4'd1;
    for (int k = 0; k < maxn; k++) begin
      exp_q.push_back(v);
      if (v < l) v = v + 4'd1;
      else break;
    end
  endtask

  task automatic start_run(input logic [W-1:0] i, input logic [W-1:0] l);
    start = 1'b1;
    init  = i;
    limit = l;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("load_no_valid", cnt_valid, 0);
    tick();
    chk("first_valid_latency", cnt_valid, 1);
  endtask

  task automatic wait_done(input logic [W-1:0] exp_final, input string tag);
    bit seen;
    int d0;
    seen = 1'b0;
    d0   = n_done;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    if (seen) chk({tag, "_done_latency"}, cyc, acc_cyc + 1);
    tick();
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_final_cnt"}, final_cnt, exp_final);
    chk({tag, "_beats_left"}, exp_q.size(), 0);
    chk({tag, "_done_count"}, n_done - d0, 1);
  endtask

  initial begin
    int nd;
    rst_n     = 1'b0;
    start     = 1'b0;
    init      = '0;
    limit     = '0;
    abort     = 1'b0;
    cnt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", cnt, 0);
    chk("rst_valid", cnt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_final", final_cnt, 0);

    // first start right after reset release
    rst_n = 1'b1;
    push_model(4'd0, 4'd14, 16);
    start_run(4'd0, 4'd14);
    wait_done(4'd14, "A");

    push_model(4'd14, 4'd14, 16);
    start_run(4'd14, 4'd14);
    wait_done(4'd15, "B");

    push_model(4'd15, 4'd3, 16);
    start_run(4'd15, 4'd3);
    wait_done(4'd3, "C");

    // backpressure on beat 2, with start/init/limit wiggled mid-run
    push_model(4'd0, 4'd4, 16);
    start_run(4'd0, 4'd4);
    tick();
    cnt_ready = 1'b0;
    start     = 1'b1;
    init      = 4'd9;
    limit     = 4'd1;
    tick();
    start = 1'b0;
    chk("D_stall_cnt", cnt, 2);
    tick();
    tick();
    chk("D_stall_valid", cnt_valid, 1);
    cnt_ready = 1'b1;
    wait_done(4'd4, "D");

    // abort on beat 5 beats the simultaneous acceptance
    push_model(4'd0, 4'd10, 4);
    start_run(4'd0, 4'd10);
    tick();
    start = 1'b1;
    init  = 4'd12;
    limit = 4'd13;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("E_cnt_at_abort", cnt, 5);
    nd    = n_done;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("E_busy_after_abort", busy, 0);
    chk("E_valid_after_abort", cnt_valid, 0);
    chk("E_final_kept", final_cnt, 4);
    chk("E_beats_left", exp_q.size(), 0);
    repeat (3) tick();
    chk("E_no_done", n_done - nd, 0);

    // start together with abort in IDLE is dropped
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick();
    chk("abort_start_valid", cnt_valid, 0);

    // asynchronous reset mid-run at beat 6
    push_model(4'd0, 4'd10, 5);
    start_run(4'd0, 4'd10);
    repeat (5) tick();
    chk("F_cnt_before_rst", cnt, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("F_rst_cnt", cnt, 0);
    chk("F_rst_valid", cnt_valid, 0);
    chk("F_rst_busy", busy, 0);
    chk("F_rst_done", done, 0);
    chk("F_rst_final", final_cnt, 0);
    chk("F_beats_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_model(4'd2, 4'd3, 16);
    start_run(4'd2, 4'd3);
    wait_done(4'd3, "F");

    chk("done_total", n_done, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/loop_counter_seq.md
LOOP_COUNTER_SEQ -- requirements
Module: loop_counter_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  begin a loop run; sampled only in IDLE.
REQ-005 SHALL have port init  input  WIDTH  counter value loaded on accepted start.
REQ-006 SHALL have port limit  input  WIDTH  loop bound, captured on accepted start.
REQ-007 SHALL have port abort  input  1  synchronous cancel of an active run.
REQ-008 SHALL have port cnt  output  WIDTH  current iteration value presented downstream.
REQ-009 SHALL have port cnt_valid  output  1  cnt holds a beat for the consumer.
REQ-010 SHALL have port cnt_ready  input  1  consumer accepts the beat when high with cnt_valid.
REQ-011 SHALL have port busy  output  1  high from accepted start until return to IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on normal loop completion.
REQ-013 SHALL have port final_cnt  output  WIDTH  last counter value, held until next accepted start.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: start high -> capture init into counter, limit into limit register, go LOAD; busy high from next cycle.
REQ-016 LOAD: counter <= counter+1 (modulo 2^WIDTH), go RUN; body always executes at least once (do-while).
REQ-017 RUN: cnt_valid high, cnt = counter; cnt and cnt_valid SHALL stay stable while cnt_ready low.
REQ-018 RUN, beat accepted (cnt_valid & cnt_ready): if counter < limit (unsigned) -> counter+1, stay RUN; else -> DONE, final_cnt <= counter.
REQ-019 DONE: done high for exactly one cycle, cnt_valid low, then IDLE; busy low in IDLE.
REQ-020 Counter increment SHALL wrap 2^WIDTH-1 -> 0 with no saturation or flag.
REQ-021 Run SHALL terminate within 2^WIDTH beats for any init/limit.
REQ-022 limit=0 or init>=limit (no wrap to below limit) -> exactly one beat, value init+1.
REQ-023 init = 2^WIDTH-1 -> first beat 0; run continues up to limit.
REQ-024 start while busy SHALL be ignored; init/limit changes during a run SHALL have no effect.
REQ-025 abort in LOAD/RUN/DONE -> IDLE next cycle, no done pulse, final_cnt unchanged; abort wins over a simultaneous beat acceptance.
REQ-026 abort in IDLE SHALL be ignored; abort and start together in IDLE -> start ignored.
REQ-027 Latency: start at edge N -> first cnt_valid at edge N+2; last accepted beat at edge M -> done at M+1.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, counter=0, limit reg=0, cnt=0, cnt_valid=0, busy=0, done=0, final_cnt=0.
REQ-029 Reset assertion mid-run SHALL abandon the run without a done pulse; release resumes in IDLE.
REQ-030 First start accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 State enum (IDLE, LOAD, RUN, DONE) and default WIDTH constant SHALL live in shared package loop_seq_pkg.
REQ-032 Single module; no sub-module required; counter and FSM in one always_ff block with rst_n in sensitivity.

Verification
REQ-033 init=0, limit=14, cnt_ready=1 -> beats 1..14 on consecutive cycles, done once, final_cnt=14.
REQ-034 init=14, limit=14 -> single beat cnt=15, done, final_cnt=15.
REQ-035 init=15, limit=3 -> beats 0,1,2,3, final_cnt=3 (wrap case).
REQ-036 init=0, limit=4, cnt_ready low 3 cycles on beat 2 -> cnt held at 2 with cnt_valid high, beats 1..4 in order, no loss/duplication.
REQ-037 init=0, limit=10, abort on beat 5 -> IDLE next cycle, no done, final_cnt keeps prior value; start during run ignored.
REQ-038 rst_n pulled low at beat 6 -> all outputs 0 immediately (asynchronous), new run from init=2, limit=3 yields beats 3 only.
